cw_output: RTL and testbench



---
 rtl/cw_output_pkg.sv | 17 +
 rtl/cw_output_vc.sv | 70 +++++++
 rtl/cw_output.sv | 72 +++++++
 tb/tb_cw_output.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cw_output_pkg.sv
// Shared ring-router definitions: packet geometry, VC parity encoding and
// the requester encoding used by the per-VC round-robin pointers.
package cw_output_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int HOP_MSB    = 55;
    localparam int HOP_LSB    = 48;

    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;

    typedef enum logic {
        REQ_CW = 1'b0,
        REQ_PE = 1'b1
    } req_t;

endpackage

// File: rtl/cw_output_vc.sv
// One virtual channel of the clockwise output port: cw/PE round-robin
// arbitration, one-packet slot and saturating hop decrement on capture.
module cw_output_vc #(
    parameter logic PARITY     = cw_output_pkg::VC_EVEN,
    parameter int   DATA_WIDTH = cw_output_pkg::DATA_WIDTH,
    parameter int   HOP_MSB    = cw_output_pkg::HOP_MSB,
    parameter int   HOP_LSB    = cw_output_pkg::HOP_LSB
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  polarity,
    input  logic                  req_cw,
    input  logic                  req_pe,
    input  logic [DATA_WIDTH-1:0] data_cw,
    input  logic [DATA_WIDTH-1:0] data_pe,
    input  logic                  load,
    output logic                  grant_cw,
    output logic                  grant_pe,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] slot_data
);
    import cw_output_pkg::*;

    localparam int HOP_W = HOP_MSB - HOP_LSB + 1;

    req_t rr;
    logic accept;
    logic pick_pe;

    function automatic logic [DATA_WIDTH-1:0] dec_hop(input logic [DATA_WIDTH-1:0] pkt);
        logic [DATA_WIDTH-1:0] res;
        logic [HOP_W-1:0]      hop;
        res = pkt;
        hop = pkt[HOP_MSB:HOP_LSB];
        if (hop != '0)
            res[HOP_MSB:HOP_LSB] = hop - HOP_W'(1);
        return res;
    endfunction

    // Requests are only considered in this VC's own phase and only into an empty slot.
    assign accept  = (polarity == PARITY) && !full && (req_cw || req_pe);
    assign pick_pe = req_pe && (!req_cw || rr == REQ_PE);

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cw <= 1'b0;
            grant_pe <= 1'b0;
            full     <= 1'b0;
            rr       <= REQ_CW;
        end else begin
            grant_cw <= accept && !pick_pe;
            grant_pe <= accept && pick_pe;
            if (accept)
                rr <= pick_pe ? REQ_CW : REQ_PE;
            if (grant_cw || grant_pe)
                full <= 1'b1;
            else if (load)
                full <= 1'b0;
        end
    end

    // Slot contents are qualified by full, so they need no reset.
    always_ff @(posedge clk) begin
        if (grant_cw)
            slot_data <= dec_hop(data_cw);
        else if (grant_pe)
            slot_data <= dec_hop(data_pe);
    end

endmodule

// File: rtl/cw_output.sv
// Clockwise output port: two parity-interleaved VCs sharing one link,
// with registered cwso/cwdo towards the downstream cw_input.
module cw_output #(
    parameter int DATA_WIDTH = cw_output_pkg::DATA_WIDTH,
    parameter int HOP_MSB    = cw_output_pkg::HOP_MSB,
    parameter int HOP_LSB    = cw_output_pkg::HOP_LSB
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  polarity,
    input  logic                  request_from_cw_even,
    input  logic                  request_from_cw_odd,
    input  logic                  request_from_pe_even,
    input  logic                  request_from_pe_odd,
    input  logic [DATA_WIDTH-1:0] data_from_cw_even,
    input  logic [DATA_WIDTH-1:0] data_from_cw_odd,
    input  logic [DATA_WIDTH-1:0] data_from_pe_even,
    input  logic [DATA_WIDTH-1:0] data_from_pe_odd,
    output logic                  grant_cw_even,
    output logic                  grant_cw_odd,
    output logic                  grant_pe_even,
    output logic                  grant_pe_odd,
    output logic                  cwso,
    input  logic                  cwro,
    output logic [DATA_WIDTH-1:0] cwdo
);
    import cw_output_pkg::*;

    logic                  full_even, full_odd;
    logic [DATA_WIDTH-1:0] slot_even, slot_odd;
    logic                  load_even, load_odd;

    // Each VC drains in the opposite phase to the one it accepts in, so at most one loads.
    assign load_even = (polarity != VC_EVEN) && full_even && cwro;
    assign load_odd  = (polarity != VC_ODD)  && full_odd  && cwro;

    cw_output_vc #(
        .PARITY(VC_EVEN), .DATA_WIDTH(DATA_WIDTH), .HOP_MSB(HOP_MSB), .HOP_LSB(HOP_LSB)
    ) u_vc_even (
        .clk(clk), .rst(rst), .polarity(polarity),
        .req_cw(request_from_cw_even), .req_pe(request_from_pe_even),
        .data_cw(data_from_cw_even), .data_pe(data_from_pe_even),
        .load(load_even),
        .grant_cw(grant_cw_even), .grant_pe(grant_pe_even),
        .full(full_even), .slot_data(slot_even)
    );

    cw_output_vc #(
        .PARITY(VC_ODD), .DATA_WIDTH(DATA_WIDTH), .HOP_MSB(HOP_MSB), .HOP_LSB(HOP_LSB)
    ) u_vc_odd (
        .clk(clk), .rst(rst), .polarity(polarity),
        .req_cw(request_from_cw_odd), .req_pe(request_from_pe_odd),
        .data_cw(data_from_cw_odd), .data_pe(data_from_pe_odd),
        .load(load_odd),
        .grant_cw(grant_cw_odd), .grant_pe(grant_pe_odd),
        .full(full_odd), .slot_data(slot_odd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cwso <= 1'b0;
            cwdo <= '0;
        end else begin
            cwso <= load_even || load_odd;
            if (load_even)
                cwdo <= slot_even;
            else if (load_odd)
                cwdo <= slot_odd;
        end
    end

endmodule

// File: tb/tb_cw_output.sv
// Directed bench for cw_output: single packet, odd-VC contention,
// backpressure, interleaved VCs, hop saturation and mid-grant reset.
module tb_cw_output;
    import cw_output_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        polarity;
    logic        request_from_cw_even, request_from_cw_odd;
    logic        request_from_pe_even, request_from_pe_odd;
    logic [63:0] data_from_cw_even, data_from_cw_odd;
    logic [63:0] data_from_pe_even, data_from_pe_odd;
    logic        grant_cw_even, grant_cw_odd, grant_pe_even, grant_pe_odd;
    logic        cwso;
    logic        cwro;
    logic [63:0] cwdo;

    int errors = 0;
    int checks = 0;

    cw_output dut (
        .clk(clk), .rst(rst), .polarity(polarity),
        .request_from_cw_even(request_from_cw_even), .request_from_cw_odd(request_from_cw_odd),
        .request_from_pe_even(request_from_pe_even), .request_from_pe_odd(request_from_pe_odd),
        .data_from_cw_even(data_from_cw_even), .data_from_cw_odd(data_from_cw_odd),
        .data_from_pe_even(data_from_pe_even), .data_from_pe_odd(data_from_pe_odd),
        .grant_cw_even(grant_cw_even), .grant_cw_odd(grant_cw_odd),
        .grant_pe_even(grant_pe_even), .grant_pe_odd(grant_pe_odd),
        .cwso(cwso), .cwro(cwro), .cwdo(cwdo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        polarity = ~polarity;
    endtask

    task automatic align(input logic p);
        if (polarity != p) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [63:0] expq[$];
    logic [63:0] exp_pkt;
    logic        exp_pe;
    logic        exp_so;
    int          ngrants;
    int          nsent;

    initial begin
        rst = 1'b1; polarity = 1'b0; cwro = 1'b1;
        request_from_cw_even = 0; request_from_cw_odd = 0;
        request_from_pe_even = 0; request_from_pe_odd = 0;
        data_from_cw_even = '0; data_from_cw_odd = '0;
        data_from_pe_even = '0; data_from_pe_odd = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_cwso", {63'd0, cwso}, 64'd0);
        chk("reset_cwdo", cwdo, 64'd0);
        chk("reset_grants", {60'd0, grant_cw_even, grant_cw_odd, grant_pe_even, grant_pe_odd}, 64'd0);

        // Single even packet from PE, hop 3 -> 2
        align(1'b0);
        request_from_pe_even = 1'b1;
        data_from_pe_even    = 64'h0003_0000_0000_00A5;
        tick();
        chk("single_grant_pe_even", {63'd0, grant_pe_even}, 64'd1);
        chk("single_grant_cw_even", {63'd0, grant_cw_even}, 64'd0);
        request_from_pe_even = 1'b0;
        tick();
        chk("single_grant_pulse_end", {63'd0, grant_pe_even}, 64'd0);
        tick();
        chk("single_cwso_t3", {63'd0, cwso}, 64'd0);
        tick();
        chk("single_cwso_t4", {63'd0, cwso}, 64'd1);
        chk("single_phase_t4", {63'd0, polarity}, 64'd0);
        chk("single_cwdo", cwdo, 64'h0002_0000_0000_00A5);
        tick();
        chk("single_cwso_t5", {63'd0, cwso}, 64'd0);
        chk("single_cwdo_hold", cwdo, 64'h0002_0000_0000_00A5);

        // Odd contention: grants alternate cw, pe, cw, ...
        align(1'b1);
        request_from_cw_odd = 1'b1; data_from_cw_odd = 64'h0005_0000_0000_0C01;
        request_from_pe_odd = 1'b1; data_from_pe_odd = 64'h0007_0000_0000_0E01;
        exp_pe = 1'b0; ngrants = 0; nsent = 0;
        for (int k = 0; k < 40 && nsent < 6; k++) begin
            tick();
            chk("odd_grant_onehot", {63'd0, grant_cw_odd & grant_pe_odd}, 64'd0);
            if (grant_cw_odd || grant_pe_odd) begin
                chk("odd_rr_winner", {63'd0, grant_pe_odd}, {63'd0, exp_pe});
                expq.push_back(exp_pe ? 64'h0006_0000_0000_0E01 : 64'h0004_0000_0000_0C01);
                exp_pe = ~exp_pe;
                ngrants++;
                if (ngrants == 6) begin
                    request_from_cw_odd = 1'b0;
                    request_from_pe_odd = 1'b0;
                end
            end
            if (cwso) begin
                chk("odd_link_phase", {63'd0, polarity}, 64'd1);
                chk("odd_queue_nonempty", {63'd0, expq.size() != 0}, 64'd1);
                if (expq.size() != 0) chk("odd_link_data", cwdo, expq.pop_front());
                nsent++;
            end
        end
        chk("odd_sent_count", 64'(nsent), 64'd6);
        chk("odd_grant_count", 64'(ngrants), 64'd6);
        repeat (3) tick();

        // Backpressure on even VC
        cwro = 1'b0;
        align(1'b0);
        request_from_cw_even = 1'b1;
        data_from_cw_even    = 64'h0010_0000_0000_0B0B;
        tick();
        chk("bp_grant_cw_even", {63'd0, grant_cw_even}, 64'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_no_cwso", {63'd0, cwso}, 64'd0);
            chk("bp_no_even_grant", {63'd0, grant_cw_even | grant_pe_even}, 64'd0);
        end
        request_from_cw_even = 1'b0;
        chk("bp_release_phase", {63'd0, polarity}, 64'd1);
        cwro = 1'b1;
        tick();
        chk("bp_release_cwso", {63'd0, cwso}, 64'd1);
        chk("bp_release_cwdo", cwdo, 64'h000F_0000_0000_0B0B);
        tick();
        chk("bp_after_cwso", {63'd0, cwso}, 64'd0);

        // Both VCs interleaved at full rate
        align(1'b0);
        request_from_cw_even = 1'b1; data_from_cw_even = 64'h0021_0000_0000_E0E0;
        request_from_pe_odd  = 1'b1; data_from_pe_odd  = 64'h0031_0000_0000_0D0D;
        for (int k = 1; k < 20; k++) begin
            tick();
            exp_so = (k >= 4) && ((k % 4 == 0) || (k % 4 == 1));
            chk("ilv_cwso", {63'd0, cwso}, {63'd0, exp_so});
            if (cwso) begin
                exp_pkt = polarity ? 64'h0030_0000_0000_0D0D : 64'h0020_0000_0000_E0E0;
                chk("ilv_cwdo", cwdo, exp_pkt);
            end
        end
        request_from_cw_even = 1'b0;
        request_from_pe_odd  = 1'b0;
        repeat (6) tick();

        // Hop field saturates at zero
        align(1'b0);
        request_from_cw_even = 1'b1;
        data_from_cw_even    = 64'hFF00_1234_5678_9ABC;
        tick();
        chk("hop0_grant_cw_even", {63'd0, grant_cw_even}, 64'd1);
        request_from_cw_even = 1'b0;
        repeat (3) tick();
        chk("hop0_cwso", {63'd0, cwso}, 64'd1);
        chk("hop0_cwdo", cwdo, 64'hFF00_1234_5678_9ABC);
        tick();

        // Reset during the grant cycle
        align(1'b0);
        request_from_cw_even = 1'b1;
        request_from_pe_even = 1'b1;
        data_from_pe_even    = 64'h0009_0000_0000_5555;
        tick();
        chk("rst_pre_grant_pe_even", {63'd0, grant_pe_even}, 64'd1);
        rst = 1'b1;
        request_from_cw_even = 1'b0;
        request_from_pe_even = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_cwso", {63'd0, cwso}, 64'd0);
        chk("rst_cwdo", cwdo, 64'd0);
        chk("rst_grants", {60'd0, grant_cw_even, grant_cw_odd, grant_pe_even, grant_pe_odd}, 64'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rst_slot_empty_cwso", {63'd0, cwso}, 64'd0);
            chk("rst_slot_empty_cwdo", cwdo, 64'd0);
        end
        align(1'b0);
        request_from_cw_even = 1'b1;
        request_from_pe_even = 1'b1;
        tick();
        chk("rst_rr_cw_first", {62'd0, grant_cw_even, grant_pe_even}, 64'd2);
        request_from_cw_even = 1'b0;
        request_from_pe_even = 1'b0;
        repeat (3) tick();
        chk("rst_after_cwso", {63'd0, cwso}, 64'd1);
        chk("rst_after_cwdo", cwdo, 64'hFF00_1234_5678_9ABC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
